serial_add_unit: RTL and testbench

- Bit-serial adder stage that drives a half-adder pair (full-adder cell) one bit per clock, LSB first.
- A carry flip-flop carries between bit slices.
- Accepts two WIDTH-bit operands on a Start pulse and returns the registered Sum, Cout and signed Overflow after WIDTH shift cycles, with a one-cycle Done strobe.
- Sits between the operand source (register file or testbench) and the combinational add cell, and sequences that cell.

---
 rtl/serial_add_unit.sv | 110 +++++++++++
 tb/tb_serial_add_unit.sv | 175 +++++++++++++++++
 2 files changed

// File: rtl/serial_add_unit.sv
// Bit-serial adder: one full-adder slice per clock, LSB first, with registered Sum/Cout/Overflow.
// Define SERIAL_ADD_SUB_EN to add a Sub input that computes A-B in two's complement.
module serial_add_unit #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             CLK,
  input  logic             Reset_L,
  input  logic             Start,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             Cin,
`ifdef SERIAL_ADD_SUB_EN
  input  logic             Sub,
`endif
  output logic             Busy,
  output logic             Done,
  output logic [WIDTH-1:0] Sum,
  output logic             Cout,
  output logic             Overflow
);

  localparam int unsigned CntW = $clog2(WIDTH);
  localparam logic [CntW-1:0] CntLast = CntW'(WIDTH - 1);

  typedef enum logic [1:0] {StIdle, StShift, StDone} state_e;

  state_e           state_q;
  logic [WIDTH-1:0] a_sh_q, b_sh_q, r_sh_q, sum_q;
  logic [CntW-1:0]  cnt_q;
  logic             c_q, busy_q, done_q, cout_q, ovf_q;

  logic             s_bit, c_next, c_load;
  logic [WIDTH-1:0] b_load;

  always_comb begin
    s_bit  = a_sh_q[0] ^ b_sh_q[0] ^ c_q;
    c_next = (a_sh_q[0] & b_sh_q[0]) | (c_q & (a_sh_q[0] ^ b_sh_q[0]));
    b_load = B;
    c_load = Cin;
`ifdef SERIAL_ADD_SUB_EN
    if (Sub) begin
      b_load = ~B;
      c_load = 1'b1;
    end
`endif
  end

  always_ff @(posedge CLK) begin
    if (!Reset_L) begin
      state_q <= StIdle;
      a_sh_q  <= '0;
      b_sh_q  <= '0;
      r_sh_q  <= '0;
      cnt_q   <= '0;
      c_q     <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      case (state_q)
        StIdle: begin
          done_q <= 1'b0;
          if (Start) begin
            a_sh_q  <= A;
            b_sh_q  <= b_load;
            c_q     <= c_load;
            cnt_q   <= '0;
            r_sh_q  <= '0;
            busy_q  <= 1'b1;
            state_q <= StShift;
          end
        end
        StShift: begin
          r_sh_q <= {s_bit, r_sh_q[WIDTH-1:1]};
          a_sh_q <= {1'b0, a_sh_q[WIDTH-1:1]};
          b_sh_q <= {1'b0, b_sh_q[WIDTH-1:1]};
          c_q    <= c_next;
          cnt_q  <= cnt_q + 1'b1;
          if (cnt_q == CntLast) begin
            // On the MSB slice c_q is still the carry into the MSB.
            sum_q   <= {s_bit, r_sh_q[WIDTH-1:1]};
            cout_q  <= c_next;
            ovf_q   <= c_q ^ c_next;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            state_q <= StDone;
          end
        end
        StDone: begin
          done_q  <= 1'b0;
          state_q <= StIdle;
        end
        default: begin
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
          state_q <= StIdle;
        end
      endcase
    end
  end

  assign Busy     = busy_q;
  assign Done     = done_q;
  assign Sum      = sum_q;
  assign Cout     = cout_q;
  assign Overflow = ovf_q;

endmodule

// File: tb/tb_serial_add_unit.sv
// Self-checking bench for serial_add_unit: directed cases plus random operands against an
// arithmetic reference model.
module tb_serial_add_unit;

  localparam int unsigned W = 8;

  logic         clk, rst_n, start, cin, sub;
  logic [W-1:0] op_a, op_b;
  logic         busy, done, cout, ovf;
  logic [W-1:0] sum;

  int unsigned n_checks = 0;
  int unsigned n_pass   = 0;

  logic [W-1:0] prev_sum;
  logic         prev_cout, prev_ovf;

  serial_add_unit #(.WIDTH(W)) u_dut (
    .CLK      (clk),
    .Reset_L  (rst_n),
    .Start    (start),
    .A        (op_a),
    .B        (op_b),
    .Cin      (cin),
`ifdef SERIAL_ADD_SUB_EN
    .Sub      (sub),
`endif
    .Busy     (busy),
    .Done     (done),
    .Sum      (sum),
    .Cout     (cout),
    .Overflow (ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    else n_pass++;
  endtask

  // Reference: plain integer arithmetic on the effective operands.
  task automatic model(input logic [W-1:0] a, input logic [W-1:0] b, input logic c, input logic s,
                       output logic [W-1:0] e_sum, output logic e_cout, output logic e_ovf);
    longint unsigned bb, cc, tot;
    bb     = s ? longint'((~b) & {W{1'b1}}) : longint'(b);
    cc     = s ? 1 : longint'(c);
    tot    = longint'(a) + bb + cc;
    e_sum  = tot[W-1:0];
    e_cout = tot[W];
    e_ovf  = (a[W-1] == bb[W-1]) && (e_sum[W-1] != a[W-1]);
  endtask

  // Called at a negedge with the DUT idle; returns at the negedge where the next Start may go.
  task automatic do_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic c,
                       input logic s, input logic hold);
    logic [W-1:0] e_sum;
    logic         e_cout, e_ovf;
    model(a, b, c, s, e_sum, e_cout, e_ovf);
    op_a  = a;
    op_b  = b;
    cin   = c;
    sub   = s;
    start = 1'b1;
    for (int i = 0; i < int'(W); i++) begin
      @(negedge clk);
      if (!hold) start = 1'b0;
      if (i == int'(W / 2)) begin
        op_a = '1;
        op_b = '1;
        cin  = ~c;
        sub  = ~s;
      end
      check("busy_shift", busy, 1'b1);
      check("done_shift", done, 1'b0);
      check("sum_hold", sum, prev_sum);
      check("cout_hold", cout, prev_cout);
    end
    @(negedge clk);
    check("done_strobe", done, 1'b1);
    check("busy_done", busy, 1'b0);
    check("sum", sum, e_sum);
    check("cout", cout, e_cout);
    check("ovf", ovf, e_ovf);
    prev_sum  = e_sum;
    prev_cout = e_cout;
    prev_ovf  = e_ovf;
    @(negedge clk);
    check("done_drop", done, 1'b0);
    check("busy_idle", busy, 1'b0);
    check("ovf_hold", ovf, prev_ovf);
  endtask

  initial begin
    rst_n = 1'b0;
    start = 1'b0;
    cin   = 1'b0;
    sub   = 1'b0;
    op_a  = '0;
    op_b  = '0;
    prev_sum  = '0;
    prev_cout = 1'b0;
    prev_ovf  = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_busy", busy, 1'b0);
    check("rst_done", done, 1'b0);
    check("rst_sum", sum, '0);
    check("rst_cout", cout, 1'b0);
    check("rst_ovf", ovf, 1'b0);
    rst_n = 1'b1;
    @(negedge clk);

    do_op(8'h5A, 8'h3C, 1'b0, 1'b0, 1'b0);
    do_op(8'hFF, 8'h01, 1'b0, 1'b0, 1'b0);
    do_op(8'h00, 8'h00, 1'b1, 1'b0, 1'b0);

    // Start held high: one operation per W+2 cycles, Start ignored in DONE.
    for (int k = 0; k < 3; k++) do_op(8'h10, 8'h20, 1'b0, 1'b0, 1'b1);
    do_op(8'h7F, 8'h01, 1'b0, 1'b0, 1'b0);
    do_op(8'h80, 8'h80, 1'b0, 1'b0, 1'b0);

    // Reset mid-SHIFT discards the operation with no Done.
    op_a  = 8'h33;
    op_b  = 8'h44;
    cin   = 1'b0;
    start = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      start = 1'b0;
    end
    rst_n = 1'b0;
    @(negedge clk);
    check("mid_rst_busy", busy, 1'b0);
    check("mid_rst_done", done, 1'b0);
    check("mid_rst_sum", sum, '0);
    check("mid_rst_cout", cout, 1'b0);
    check("mid_rst_ovf", ovf, 1'b0);
    rst_n = 1'b1;
    prev_sum  = '0;
    prev_cout = 1'b0;
    prev_ovf  = 1'b0;
    for (int i = 0; i < int'(W) + 2; i++) begin
      @(negedge clk);
      check("post_rst_done", done, 1'b0);
      check("post_rst_busy", busy, 1'b0);
    end
    do_op(8'h01, 8'h02, 1'b0, 1'b0, 1'b0);

`ifdef SERIAL_ADD_SUB_EN
    do_op(8'h10, 8'h20, 1'b0, 1'b1, 1'b0);
    do_op(8'h80, 8'h01, 1'b0, 1'b1, 1'b0);
`endif

    for (int k = 0; k < 40; k++) begin
      logic [W-1:0] ra, rb;
      logic         rc, rs;
      ra = W'($urandom);
      rb = W'($urandom);
      rc = 1'($urandom);
`ifdef SERIAL_ADD_SUB_EN
      rs = 1'($urandom);
`else
      rs = 1'b0;
`endif
      do_op(ra, rb, rc, rs, 1'($urandom_range(0, 1)));
    end
    start = 1'b0;

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
